// File: rtl/src_pkt_gen_pkg.sv
// Shared types, constants and helpers for the NoC packet traffic source.
package lynx_tg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tg_state_e;

  localparam int DEST_MODE_RR   = 0;
  localparam int DEST_MODE_RAND = 1;

  localparam int SOP_EOP_W  = 2;
  localparam int SRC_ID_W   = 8;
  localparam int FLIT_IDX_W = 4;

  // The sequence number takes every flit bit not claimed by the fixed fields.
  function automatic int seq_width(input int width, input int n_addr_w, input int vc_addr_w);
    return width - SOP_EOP_W - SRC_ID_W - FLIT_IDX_W - 2 * n_addr_w - vc_addr_w;
  endfunction

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ 16'hB400) : (cur >> 1);
  endfunction

endpackage

// File: rtl/src_pkt_gen_if.sv
// Flit link from the traffic source towards a router input port.
interface src_pkt_gen_if #(
  parameter int WIDTH         = 36,
  parameter int N_ADDR_WIDTH  = 4,
  parameter int VC_ADDR_WIDTH = 1
);
  logic [WIDTH-1:0]         data_out;
  logic [N_ADDR_WIDTH-1:0]  dest_out;
  logic [VC_ADDR_WIDTH-1:0] vc_out;
  logic                     sop_out;
  logic                     eop_out;
  logic                     valid_out;
  logic                     ready_in;

  modport master (
    output data_out, dest_out, vc_out, sop_out, eop_out, valid_out,
    input  ready_in
  );

  modport slave (
    input  data_out, dest_out, vc_out, sop_out, eop_out, valid_out,
    output ready_in
  );
endinterface

// File: rtl/src_pkt_gen_rate_ctrl.sv
// Token accumulator pacing packet starts to RATE_NUM per RATE_DEN cycles.
module tg_rate_ctrl #(
  parameter int RATE_NUM = 1,
  parameter int RATE_DEN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic consume,
  output logic eligible
);
  import lynx_tg_pkg::*;

  localparam int TOK_MAX = 2 * RATE_DEN - 1;
  localparam int TW      = $clog2(2 * RATE_DEN + RATE_NUM + 1);

  logic [TW-1:0] tok;
  logic [TW-1:0] tok_sum;
  logic [TW-1:0] tok_next;

  // consume is only raised while eligible, so the subtraction cannot underflow.
  always_comb begin
    tok_sum = tok + TW'(RATE_NUM);
    if (consume) tok_sum = tok_sum - TW'(RATE_DEN);
    tok_next = (tok_sum > TW'(TOK_MAX)) ? TW'(TOK_MAX) : tok_sum;
  end

  assign eligible = (tok >= TW'(RATE_DEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tok <= '0;
    else        tok <= tok_next;
  end

endmodule

// File: rtl/src_pkt_gen.sv
// Multi-flit NoC traffic source: rate-paced packet injection with RR or LFSR
// destination choice, sop/eop/index/sequence tagging and a done flag.
module src_pkt_gen
  import lynx_tg_pkg::*;
#(
  parameter int          WIDTH         = 36,
  parameter int          N             = 16,
  parameter int          NUM_VC        = 2,
  parameter int          N_ADDR_WIDTH  = $clog2(N),
  parameter int          VC_ADDR_WIDTH = $clog2(NUM_VC),
  parameter logic [7:0]  ID            = 8'd0,
  parameter int          NODE          = 15,
  parameter int          NUM_DEST      = 4,
  parameter int unsigned DEST [NUM_DEST] = '{NUM_DEST{1}},
  parameter int unsigned VC   [NUM_DEST] = '{NUM_DEST{1}},
  parameter int          PKT_LEN       = 1,
  parameter int          RATE_NUM      = 1,
  parameter int          RATE_DEN      = 1,
  parameter int          DEST_MODE     = 0,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int unsigned NUM_TESTS     = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  src_pkt_gen_if.master link,
  output logic [31:0]  pkt_count,
  output logic         done
);

  localparam int          SEQ_W    = seq_width(WIDTH, N_ADDR_WIDTH, VC_ADDR_WIDTH);
  localparam int          IDX_W    = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'd1 : SEED;
  localparam logic [3:0]  LAST_IDX = 4'(PKT_LEN - 1);
  localparam logic [1:0]  ST_IDLE  = IDLE;
  localparam logic [1:0]  ST_SEND  = SEND;
  localparam logic [1:0]  ST_DONE  = DONE;

  logic [1:0]               state;
  logic                     valid;
  logic                     sop;
  logic                     eop;
  logic [3:0]               fidx;
  logic [SEQ_W-1:0]         seq;
  logic [N_ADDR_WIDTH-1:0]  dest;
  logic [VC_ADDR_WIDTH-1:0] vc;
  logic [IDX_W-1:0]         rr_idx;
  logic [IDX_W-1:0]         rr_nxt;
  logic [IDX_W-1:0]         sel_idx;
  logic [15:0]              lfsr;
  logic [15:0]              lfsr_nxt;
  logic [N_ADDR_WIDTH-1:0]  dest_sel;
  logic [VC_ADDR_WIDTH-1:0] vc_sel;
  logic                     eligible;
  logic                     xfer;
  logic                     last;
  logic                     more;
  logic                     start;

  tg_rate_ctrl #(
    .RATE_NUM (RATE_NUM),
    .RATE_DEN (RATE_DEN)
  ) u_rate (
    .clk      (clk),
    .rst_n    (rst_n),
    .consume  (start),
    .eligible (eligible)
  );

  assign xfer = valid && link.ready_in;
  assign last = (fidx == LAST_IDX);
  assign more = ((pkt_count + 32'd1) < NUM_TESTS);

  always_comb begin
    start = 1'b0;
    case (state)
      ST_IDLE: start = eligible && (pkt_count != NUM_TESTS);
      ST_SEND: start = xfer && last && more && eligible;
      default: start = 1'b0;
    endcase
  end

  // Random mode indexes with the LFSR value produced by this packet's step.
  assign lfsr_nxt = lfsr16_next(lfsr);
  assign rr_nxt   = (rr_idx == IDX_W'(NUM_DEST - 1)) ? '0 : rr_idx + 1'b1;
  assign sel_idx  = (DEST_MODE == DEST_MODE_RAND) ? IDX_W'(lfsr_nxt % 16'(NUM_DEST)) : rr_idx;
  assign dest_sel = N_ADDR_WIDTH'(DEST[sel_idx]);
  assign vc_sel   = VC_ADDR_WIDTH'(VC[sel_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      valid     <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      fidx      <= '0;
      seq       <= '0;
      dest      <= '0;
      vc        <= '0;
      rr_idx    <= '0;
      lfsr      <= SEED_EFF;
      pkt_count <= '0;
      done      <= 1'b0;
    end else begin
      if (start) begin
        state  <= ST_SEND;
        valid  <= 1'b1;
        sop    <= 1'b1;
        eop    <= (PKT_LEN == 1);
        fidx   <= '0;
        dest   <= dest_sel;
        vc     <= vc_sel;
        rr_idx <= rr_nxt;
        lfsr   <= lfsr_nxt;
      end
      case (state)
        ST_IDLE: begin
          if (pkt_count == NUM_TESTS) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            if (!last) begin
              fidx <= fidx + 4'd1;
              sop  <= 1'b0;
              eop  <= ((fidx + 4'd1) == LAST_IDX);
            end else begin
              pkt_count <= pkt_count + 32'd1;
              seq       <= seq + 1'b1;
              if (!start) begin
                valid <= 1'b0;
                sop   <= 1'b0;
                eop   <= 1'b0;
                state <= more ? ST_IDLE : ST_DONE;
                done  <= !more;
              end
            end
          end
        end
        ST_DONE: begin
          valid <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign link.valid_out = valid;
  assign link.sop_out   = sop;
  assign link.eop_out   = eop;
  assign link.dest_out  = dest;
  assign link.vc_out    = vc;
  assign link.data_out  = valid ? {sop, eop, N_ADDR_WIDTH'(NODE), dest, vc, ID, fidx, seq} : '0;

endmodule

// File: tb/tb_src_pkt_gen.sv
// Scoreboard bench for src_pkt_gen across four parameter sets.
module tb_src_pkt_gen;
  import lynx_tg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  localparam int unsigned DA  [3] = '{2, 5, 9};
  localparam int unsigned VCA [3] = '{0, 1, 0};
  localparam int unsigned DB  [4] = '{3, 7, 11, 14};
  localparam int unsigned VB  [4] = '{1, 0, 1, 0};

  logic        rst_a, rst_b, rst_c, rst_d;
  logic [31:0] pc_a, pc_b, pc_c, pc_d;
  logic        done_a, done_b, done_c, done_d;
  logic [35:0] qa[$], qb[$], qd[$];

  src_pkt_gen_if #(.WIDTH(36), .N_ADDR_WIDTH(4), .VC_ADDR_WIDTH(1)) if_a ();
  src_pkt_gen_if #(.WIDTH(36), .N_ADDR_WIDTH(4), .VC_ADDR_WIDTH(1)) if_b ();
  src_pkt_gen_if #(.WIDTH(36), .N_ADDR_WIDTH(4), .VC_ADDR_WIDTH(1)) if_c ();
  src_pkt_gen_if #(.WIDTH(36), .N_ADDR_WIDTH(4), .VC_ADDR_WIDTH(1)) if_d ();

  src_pkt_gen #(.ID(8'h5A), .NODE(15), .NUM_DEST(3), .DEST(DA), .VC(VCA), .PKT_LEN(4),
                .RATE_NUM(1), .RATE_DEN(1), .DEST_MODE(0), .NUM_TESTS(3))
    u_a (.clk(clk), .rst_n(rst_a), .link(if_a), .pkt_count(pc_a), .done(done_a));

  src_pkt_gen #(.ID(8'h21), .NODE(7), .NUM_DEST(4), .DEST(DB), .VC(VB), .PKT_LEN(1),
                .RATE_NUM(1), .RATE_DEN(4), .DEST_MODE(1), .SEED(16'hACE1), .NUM_TESTS(1000))
    u_b (.clk(clk), .rst_n(rst_b), .link(if_b), .pkt_count(pc_b), .done(done_b));

  src_pkt_gen #(.NUM_TESTS(0))
    u_c (.clk(clk), .rst_n(rst_c), .link(if_c), .pkt_count(pc_c), .done(done_c));

  src_pkt_gen #(.ID(8'hC3), .NODE(3), .NUM_DEST(3), .DEST(DA), .VC(VCA), .PKT_LEN(2),
                .RATE_NUM(2), .RATE_DEN(3), .DEST_MODE(0), .NUM_TESTS(7))
    u_d (.clk(clk), .rst_n(rst_d), .link(if_d), .pkt_count(pc_d), .done(done_d));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected flit: {sop, eop, node, dest, vc, id, flit_idx, seq}.
  function automatic logic [35:0] mk(input logic s, input logic e, input logic [3:0] node,
                                     input int unsigned dst, input int unsigned v,
                                     input logic [7:0] id, input int f, input int sq);
    logic [3:0]  d4 = dst[3:0];
    logic [3:0]  f4 = f[3:0];
    logic [12:0] s13 = sq[12:0];
    return {s, e, node, d4, v[0], id, f4, s13};
  endfunction

  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic fill_a();
    qa.delete();
    for (int p = 0; p < 3; p++)
      for (int f = 0; f < 4; f++)
        qa.push_back(mk(f == 0, f == 3, 4'd15, DA[p % 3], VCA[p % 3], 8'h5A, f, p));
  endtask

  task automatic fill_b();
    logic [15:0] s = 16'hACE1;
    qb.delete();
    for (int p = 0; p < 300; p++) begin
      s = lfsr_ref(s);
      qb.push_back(mk(1'b1, 1'b1, 4'd7, DB[s % 16'd4], VB[s % 16'd4], 8'h21, 0, p));
    end
  endtask

  task automatic fill_d();
    qd.delete();
    for (int p = 0; p < 7; p++)
      for (int f = 0; f < 2; f++)
        qd.push_back(mk(f == 0, f == 1, 4'd3, DA[p % 3], VCA[p % 3], 8'hC3, f, p));
  endtask

  logic [43:0] a_prev;
  bit          a_stall = 0;
  logic [35:0] ea, eb, ed;

  always @(negedge clk) begin
    if (!rst_a) a_stall = 0;
    else begin
      if (a_stall)
        check("a_stall_hold", {if_a.valid_out, if_a.sop_out, if_a.eop_out, if_a.dest_out,
                               if_a.vc_out, if_a.data_out}, a_prev);
      if (if_a.valid_out && if_a.ready_in) begin
        if (qa.size() == 0) check("a_unexpected_flit", if_a.valid_out, 1'b0);
        else begin
          ea = qa.pop_front();
          check("a_data", if_a.data_out, ea);
          check("a_ctl", {if_a.sop_out, if_a.eop_out, if_a.dest_out, if_a.vc_out},
                {ea[35:34], ea[29:26], ea[25]});
        end
      end
      a_stall = if_a.valid_out && !if_a.ready_in;
      a_prev  = {if_a.valid_out, if_a.sop_out, if_a.eop_out, if_a.dest_out, if_a.vc_out, if_a.data_out};
    end
  end

  always @(negedge clk) begin
    if (rst_b && if_b.valid_out && if_b.ready_in) begin
      if (qb.size() == 0) check("b_unexpected_flit", if_b.valid_out, 1'b0);
      else begin
        eb = qb.pop_front();
        check("b_data", if_b.data_out, eb);
        check("b_ctl", {if_b.sop_out, if_b.eop_out, if_b.dest_out, if_b.vc_out},
              {eb[35:34], eb[29:26], eb[25]});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_d && if_d.valid_out && if_d.ready_in) begin
      if (qd.size() == 0) check("d_unexpected_flit", if_d.valid_out, 1'b0);
      else begin
        ed = qd.pop_front();
        check("d_data", if_d.data_out, ed);
        check("d_ctl", {if_d.sop_out, if_d.eop_out, if_d.dest_out, if_d.vc_out},
              {ed[35:34], ed[29:26], ed[25]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=%0d exp=%0d", n_checks, -1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, cnt, gap;
    rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
    if_a.ready_in = 1; if_b.ready_in = 1; if_c.ready_in = 1; if_d.ready_in = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_rst_valid", if_a.valid_out, 1'b0);
    check("a_rst_data", if_a.data_out, 36'd0);
    check("a_rst_ctl", {if_a.sop_out, if_a.eop_out, if_a.dest_out, if_a.vc_out}, 7'd0);
    check("a_rst_cnt", pc_a, 32'd0);
    check("a_rst_done", done_a, 1'b0);
    check("c_rst_done", done_c, 1'b0);

    // NUM_TESTS = 0: done on the first edge after release, never valid
    @(posedge clk); #2 rst_c = 1;
    @(negedge clk);
    check("c_done_before_edge", done_c, 1'b0);
    @(negedge clk);
    check("c_done_first_edge", done_c, 1'b1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (if_c.valid_out) n++;
      @(negedge clk);
    end
    check("c_valid_cycles", n, 0);
    check("c_cnt", pc_c, 32'd0);

    // Full throughput, 3 packets of 4 flits
    fill_a();
    @(posedge clk); #2 rst_a = 1;
    w = 0;
    @(negedge clk);
    while (!if_a.valid_out && w < 20) begin w++; @(negedge clk); end
    check("a_first_latency", w, 2);
    n = 0;
    while (if_a.valid_out && n < 40) begin n++; @(negedge clk); end
    check("a_burst_len", n, 12);
    check("a_done_after_last", done_a, 1'b1);
    check("a_pkt_count", pc_a, 32'd3);
    check("a_q_drained", qa.size(), 0);

    // Backpressure on cycles 2..6 of packet 0
    @(posedge clk); #2 rst_a = 0;
    fill_a();
    @(posedge clk); #2 rst_a = 1;
    w = 0;
    @(negedge clk);
    while (!if_a.valid_out && w < 20) begin w++; @(negedge clk); end
    n = 1;
    for (int k = 1; k < 60 && !done_a; k++) begin
      @(posedge clk); #2 if_a.ready_in = !(k >= 2 && k <= 6);
      @(negedge clk);
      if (if_a.valid_out) n++;
    end
    if_a.ready_in = 1;
    check("a_bp_valid_cycles", n, 17);
    check("a_bp_done", done_a, 1'b1);
    check("a_bp_pkt_count", pc_a, 32'd3);
    check("a_bp_q_drained", qa.size(), 0);

    // Reset after flit 1 of packet 0
    @(posedge clk); #2 rst_a = 0;
    fill_a();
    @(posedge clk); #2 rst_a = 1;
    w = 0;
    @(negedge clk);
    while (!(if_a.valid_out && if_a.data_out[16:13] == 4'd1) && w < 40) begin w++; @(negedge clk); end
    @(posedge clk); #2;
    check("a_pre_rst_valid", if_a.valid_out, 1'b1);
    rst_a = 0;
    #1 check("a_async_drop", if_a.valid_out, 1'b0);
    fill_a();
    @(posedge clk); #2 rst_a = 1;
    w = 0;
    @(negedge clk);
    while (!if_a.valid_out && w < 20) begin w++; @(negedge clk); end
    check("a_restart_sop", if_a.sop_out, 1'b1);
    check("a_restart_seq", if_a.data_out[12:0], 13'd0);
    check("a_restart_cnt", pc_a, 32'd0);
    w = 0;
    while (!done_a && w < 60) begin w++; @(negedge clk); end
    check("a_restart_done", pc_a, 32'd3);
    check("a_restart_q_drained", qa.size(), 0);

    // Round-robin wrap with fractional rate
    fill_d();
    @(posedge clk); #2 rst_d = 1;
    w = 0;
    while (!done_d && w < 300) begin w++; @(negedge clk); end
    check("d_done", done_d, 1'b1);
    check("d_pkt_count", pc_d, 32'd7);
    check("d_q_drained", qd.size(), 0);

    // LFSR destinations at rate 1/4
    fill_b();
    @(posedge clk); #2 rst_b = 1;
    w = 0;
    @(negedge clk);
    while (!if_b.valid_out && w < 20) begin w++; @(negedge clk); end
    cnt = 0; gap = -1;
    for (int i = 0; i < 100; i++) begin
      if (if_b.valid_out && if_b.ready_in) begin
        cnt++;
        if (cnt == 2) gap = i;
      end
      @(negedge clk);
    end
    check("b_first_gap", gap, 4);
    check("b_rate_25pm1", (cnt >= 24 && cnt <= 26), 1'b1);
    check("b_not_done", done_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
